// File: rtl/apb_master.sv
// rtl/apb_master.sv - command/response channel to APB requester with wait-state timeout
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-low reset
//   cmd_valid_i/ready_o   command handshake; cmd_write_i, cmd_addr_i, cmd_wdata_i
//   rsp_valid_o/ready_i   response handshake; rsp_write_o, rsp_rdata_o, rsp_timeout_o
//   psel_o, penable_o, paddr_o, pwrite_o, pwdata_o   APB request side
//   prdata_i, pready_i                               APB completion side
module apb_master #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_write_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; the final ACCESS cycle is
  // recognised by comparison rather than by counting one past it.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic              timeout_hit;

  // Ready is also gated by reset so nothing looks accepted while held in reset.
  assign cmd_ready_o = (state == IDLE) && reset;
  assign rsp_valid_o = (state == RESP);

  always_comb begin
    state_next  = state;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_W'(LAST));
    case (state)
      IDLE:    if (cmd_valid_i) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (pready_i || timeout_hit) state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      paddr_o       <= '0;
      pwrite_o      <= 1'b0;
      pwdata_o      <= '0;
      rsp_write_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_timeout_o <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      state     <= state_next;
      // Bus strobes follow the state being entered so they are flops, not decodes.
      psel_o    <= (state_next == SETUP) || (state_next == ACCESS);
      penable_o <= (state_next == ACCESS);
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            paddr_o  <= cmd_addr_i;
            pwrite_o <= cmd_write_i;
            pwdata_o <= cmd_write_i ? cmd_wdata_i : '0;
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          // A ready on the final allowed cycle is a normal completion.
          if (pready_i) begin
            rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
            rsp_timeout_o <= 1'b0;
            rsp_write_o   <= pwrite_o;
          end else if (timeout_hit) begin
            rsp_rdata_o   <= '0;
            rsp_timeout_o <= 1'b1;
            rsp_write_o   <= pwrite_o;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) wait_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - randomized self-checking bench for apb_master
module tb_apb_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [9:0]  cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_write_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_timeout_o;
  logic        psel_o;
  logic        penable_o;
  logic [9:0]  paddr_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i;
  logic        pready_i;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] ref_mem   [1024];
  logic [31:0] slave_mem [1024];

  apb_master #(.ADDR_W(10), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_timeout_o(rsp_timeout_o),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transaction. ws = wait states the slave inserts before
  // PREADY; ws >= TO means the slave never answers and a timeout is expected.
  task automatic xfer(input bit wr, input logic [9:0] addr, input logic [31:0] wdata,
                      input int ws, input int hold, input bit keep_valid);
    int          n_sel, n_en, cyc;
    bit          exp_to;
    logic [31:0] exp_rd;
    logic [31:0] exp_pw;
    exp_to = (ws >= TO);
    exp_rd = (wr || exp_to) ? 32'h0 : ref_mem[addr];
    exp_pw = wr ? wdata : 32'h0;
    if (wr && !exp_to) ref_mem[addr] = wdata;

    @(negedge clk);
    check("cmd_ready_idle", {31'b0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wdata;
    rsp_ready_i = 1'b0; pready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Scrambled command inputs must be ignored while busy.
    if (!keep_valid) cmd_valid_i = 1'b0;
    cmd_write_i = ~wr; cmd_addr_i = ~addr; cmd_wdata_i = ~wdata;
    n_sel = 0; n_en = 0; cyc = 0;
    while (!rsp_valid_o && cyc < 100) begin
      if (psel_o) begin
        n_sel++;
        check("paddr_stable", {22'b0, paddr_o}, {22'b0, addr});
        check("pwdata_stable", pwdata_o, exp_pw);
      end
      if (penable_o) n_en++;
      pready_i = 1'b0;
      prdata_i = $urandom;
      if (penable_o && (n_en - 1 == ws)) begin
        pready_i = 1'b1;
        if (pwrite_o) slave_mem[paddr_o] = pwdata_o;
        else prdata_i = slave_mem[paddr_o];
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    pready_i = 1'b0;
    check("rsp_within_bound", {31'b0, rsp_valid_o}, 32'd1);
    check("psel_cycles", n_sel, exp_to ? TO + 1 : ws + 2);
    check("penable_cycles", n_en, exp_to ? TO : ws + 1);
    check("pwrite", {31'b0, pwrite_o}, {31'b0, wr});
    check("rsp_write", {31'b0, rsp_write_o}, {31'b0, wr});
    check("rsp_timeout", {31'b0, rsp_timeout_o}, {31'b0, exp_to});
    check("rsp_rdata", rsp_rdata_o, exp_rd);
    check("psel_in_resp", {30'b0, psel_o, penable_o}, 32'd0);
    check("cmd_ready_resp", {31'b0, cmd_ready_o}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", {31'b0, rsp_valid_o}, 32'd1);
      check("hold_rdata", rsp_rdata_o, exp_rd);
      check("hold_flags", {30'b0, rsp_write_o, rsp_timeout_o}, {30'b0, wr, exp_to});
      check("hold_bus_idle", {30'b0, psel_o, cmd_ready_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    cmd_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("rsp_drop", {31'b0, rsp_valid_o}, 32'd0);
    check("back_to_idle", {31'b0, cmd_ready_o}, 32'd1);
  endtask

  logic [9:0]  addrs [10];
  logic [31:0] datas [10];
  bit          dup;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 32'h0;
      slave_mem[i] = 32'h0;
    end
    reset = 1'b0; cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 10'h155;
    cmd_wdata_i = 32'h1234; rsp_ready_i = 1'b0; prdata_i = 32'h0; pready_i = 1'b0;

    // Reset with a pending command.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_bus", {29'b0, psel_o, penable_o, rsp_valid_o}, 32'd0);
      check("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
    end
    check("rst_paddr", {22'b0, paddr_o}, 32'd0);
    check("rst_pwdata", pwdata_o, 32'd0);
    check("rst_rsp", {rsp_rdata_o[29:0], rsp_write_o, rsp_timeout_o}, 32'd0);
    cmd_valid_i = 1'b0;
    reset = 1'b1;
    #1;
    check("post_rst_ready", {31'b0, cmd_ready_o}, 32'd1);

    // Directed cases.
    xfer(1'b1, 10'h2A5, 32'h0000BEEF, 0, 0, 1'b0);
    xfer(1'b0, 10'h2A5, 32'h0, 3, 0, 1'b0);
    xfer(1'b0, 10'h2A5, 32'h0, TO, 0, 1'b0);
    xfer(1'b0, 10'h2A5, 32'h0, TO - 1, 0, 1'b0);
    xfer(1'b1, 10'h011, 32'hCAFE0001, TO, 0, 1'b0);
    xfer(1'b0, 10'h011, 32'h0, 1, 5, 1'b1);

    // Random writes then reads to distinct addresses.
    for (int i = 0; i < 10; i++) begin
      do begin
        addrs[i] = 10'($urandom_range(0, 1023));
        dup = (addrs[i] == 10'h2A5) || (addrs[i] == 10'h011);
        for (int j = 0; j < i; j++) if (addrs[j] == addrs[i]) dup = 1'b1;
      end while (dup);
      datas[i] = $urandom;
      xfer(1'b1, addrs[i], datas[i], $urandom_range(0, 5), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 10; i++) begin
      xfer(1'b0, addrs[i], 32'h0, $urandom_range(0, 5), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      check("rand_readback", rsp_rdata_o, datas[i]);
    end

    // Reset while in ACCESS: bus idles, response discarded.
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = addrs[0];
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_access", {30'b0, psel_o, penable_o}, 32'd3);
    reset = 1'b0;
    pready_i = 1'b1;
    prdata_i = 32'hDEAD0000;
    @(posedge clk);
    @(negedge clk);
    pready_i = 1'b0;
    check("midrst_bus", {29'b0, psel_o, penable_o, rsp_valid_o}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_no_rsp", {29'b0, psel_o, rsp_valid_o, cmd_ready_o}, 32'd1);
    end
    xfer(1'b0, addrs[1], 32'h0, 2, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
